// File: rtl/common_pkg.sv
// Shared widths, the NOP encoding and the default program image for the fetch stage.
package common_pkg;

    localparam int unsigned RISC_V_DATA_WIDTH                = 32;
    localparam int unsigned INSTRUCTION_WIDTH                = 32;
    localparam int unsigned INSTRUCTION_MEMORY_ADDRESS_WIDTH = 32;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    localparam int unsigned PROGRAM_WORDS = 5;

    // Word 0 sits in the lowest slice.
    localparam logic [PROGRAM_WORDS-1:0][INSTRUCTION_WIDTH-1:0] DEFAULT_PROGRAM = {
        32'hFE00_0FCB,
        32'h0005_8133,
        32'h0005_8133,
        32'h0001_00B3,
        32'h0020_8FE3
    };

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch/decode boundary: branch controls flow into fetch, the current instruction flows out.
interface instruction_fetch_unit_if;
    import common_pkg::*;

    logic                                          ALU_zero_flag;
    logic signed [RISC_V_DATA_WIDTH-1:0]           offset;
    logic                                          ctrl_branch;
    logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0]   instruction_address;
    logic [INSTRUCTION_WIDTH-1:0]                  instruction_data;

    modport master (
        output ALU_zero_flag,
        output offset,
        output ctrl_branch,
        input  instruction_address,
        input  instruction_data
    );

    modport slave (
        input  ALU_zero_flag,
        input  offset,
        input  ctrl_branch,
        output instruction_address,
        output instruction_data
    );

endinterface

// File: rtl/fetch_rom.sv
// Combinational instruction ROM; addresses past the last word read as NOP rather than aliasing.
module fetch_rom
    import common_pkg::*;
#(
    parameter int unsigned DepthWords = 64
) (
    input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] addr_i,
    output logic [INSTRUCTION_WIDTH-1:0]                data_o
);

    localparam int unsigned IdxW = $clog2(DepthWords);

    logic [INSTRUCTION_WIDTH-1:0] rom [DepthWords];
    logic [IdxW-1:0]              idx;
    logic                         in_range;
    logic                         unused_lsb;

    for (genvar i = 0; i < DepthWords; i++) begin : g_rom
        if (i < PROGRAM_WORDS) begin : g_prog
            assign rom[i] = DEFAULT_PROGRAM[i];
        end else begin : g_nop
            assign rom[i] = NOP_INSTRUCTION;
        end
    end

    assign unused_lsb = ^addr_i[1:0];
    assign idx        = addr_i[IdxW+1:2];
    assign in_range   = ({2'b00, addr_i[INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:2]} < 32'(DepthWords));

    always_comb begin
        data_o = NOP_INSTRUCTION;
        if (in_range) begin
            data_o = rom[idx];
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register with sequential/branch next-PC selection feeding a combinational ROM.
module instruction_fetch_unit
    import common_pkg::*;
#(
    parameter int unsigned                                ROM_DEPTH_WORDS = 64,
    parameter logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.slave  fetch_io
);

    logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] branch_disp;
    logic                                        take_branch;

    assign take_branch = fetch_io.ctrl_branch & fetch_io.ALU_zero_flag;
    // Halfword immediate to byte displacement; the top offset bit falls off, which is fine mod 2^32.
    assign branch_disp = {fetch_io.offset[RISC_V_DATA_WIDTH-2:0], 1'b0};

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (take_branch) begin
            pc_d = pc_q + branch_disp;
        end
        pc_d[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fetch_io.instruction_address = pc_q;

    fetch_rom #(
        .DepthWords (ROM_DEPTH_WORDS)
    ) u_fetch_rom (
        .addr_i (pc_q),
        .data_o (fetch_io.instruction_data)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch stage against a simple PC/ROM model.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .ROM_DEPTH_WORDS (64),
        .RESET_PC        (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] model_pc    = 32'h0;
    logic [31:0] program_words [5] = '{32'h00208FE3, 32'h000100B3, 32'h00058133,
                                       32'h00058133, 32'hFE000FCB};

    function automatic logic [31:0] model_data(input logic [31:0] pc);
        logic [31:0] word;
        word = pc / 4;
        if (word < 64 && word < 5) return program_words[word];
        return 32'h00000013;
    endfunction

    task automatic check(input string tag);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        exp_addr = model_pc;
        exp_data = model_data(model_pc);
        vectors++;
        assert (bus.instruction_address === exp_addr) else begin
            miscompares++;
            $error("FAIL %s addr: observed %h expected %h", tag, bus.instruction_address, exp_addr);
        end
        vectors++;
        assert (bus.instruction_data === exp_data) else begin
            miscompares++;
            $error("FAIL %s data: observed %h expected %h", tag, bus.instruction_data, exp_data);
        end
    endtask

    // Drive inputs away from the edge, take one rising edge, advance the model, check.
    task automatic step(input logic cb, input logic zf, input int off, input logic rl,
                        input string tag);
        bus.ctrl_branch   = cb;
        bus.ALU_zero_flag = zf;
        bus.offset        = off;
        rst               = rl;
        if (!rl) model_pc = 32'h0;
        @(posedge clk);
        if (!rl) begin
            model_pc = 32'h0;
        end else begin
            if (cb && zf) model_pc = model_pc + 32'(off * 2);
            else          model_pc = model_pc + 32'd4;
            model_pc[1:0] = 2'b00;
        end
        #1;
        check(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst      = 1'b0;
        model_pc = 32'h0;
        #1;
        check(tag);
        rst = 1'b1;
    endtask

    initial begin
        bus.ctrl_branch   = 1'b0;
        bus.ALU_zero_flag = 1'b0;
        bus.offset        = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold");
        rst = 1'b1;
        #1;
        check("reset_release");

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, "seq");

        step(1'b1, 1'b1, -6, 1'b1, "branch_back");
        step(1'b0, 1'b0, 0, 1'b1, "after_branch");
        step(1'b0, 1'b0, 0, 1'b1, "seq_c");
        step(1'b0, 1'b0, 0, 1'b1, "seq_10");
        step(1'b1, 1'b0, -6, 1'b1, "cb_only");
        step(1'b0, 1'b1, -6, 1'b1, "zf_only");

        async_reset("mid_reset");
        step(1'b1, 1'b1, 32'h7E, 1'b1, "fwd_fc");
        step(1'b0, 1'b0, 0, 1'b1, "out_of_range");

        async_reset("mid_reset2");
        step(1'b1, 1'b1, 1, 1'b1, "odd_align");
        step(1'b1, 1'b1, -2, 1'b1, "wrap_back");
        step(1'b0, 1'b0, 0, 1'b1, "wrap_fwd");
        step(1'b0, 1'b0, 0, 1'b1, "seq_after_wrap");

        step(1'b1, 1'b1, 10, 1'b0, "reset_vs_branch");
        rst = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int   off;
            logic rl;
            off = int'($urandom_range(0, 60)) - 30;
            if (i % 16 == 15) off = int'($urandom);
            rl = ($urandom_range(0, 19) != 0);
            step(1'($urandom), 1'($urandom), off, rl, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the minimal single-cycle RISC-V core. It holds the program counter (PC) and reads a fixed instruction ROM combinationally at the PC. It presents the current instruction to decode every cycle. Each clock it advances sequentially, or takes a conditional branch when decode/ALU request one.

Parameters:
ROM_DEPTH_WORDS, 64, number of 32-bit words in the instruction ROM (power of two, at least 8).
RESET_PC, 0, byte address loaded into the PC on reset (word aligned).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
ALU_zero_flag  input  1  ALU result-zero flag for the current instruction
offset  input  RISC_V_DATA_WIDTH (32), signed  branch immediate in halfword units
ctrl_branch  input  1  decode says the current instruction is a conditional branch
instruction_address  output  INSTRUCTION_MEMORY_ADDRESS_WIDTH (32)  current PC, byte address
instruction_data  output  INSTRUCTION_WIDTH (32)  instruction word at the current PC

Behaviour:
- Reset:
  - rst=0 forces PC=RESET_PC immediately, independent of clk.
  - PC holds at RESET_PC while rst=0; instruction_data follows combinationally.
  - Deassertion takes effect at the first rising edge with rst=1.
  - Reset asserted mid-program overrides any pending branch.
- Branch decision: take_branch = ctrl_branch AND ALU_zero_flag.
- PC update, each rising edge with rst=1 (one register, one-cycle latency):
  - not taken: PC <= PC + 4.
  - taken: PC <= PC + (offset <<< 1); offset is sign-extended or truncated to address width before the shift.
  - The low 2 bits of the next PC are always forced to 0.
- Arithmetic wraps modulo 2^32; no overflow detection. Example: PC=0xFFFFFFFC plus 4 gives 0x00000000.
- Inputs are sampled only at the rising edge. ctrl_branch=1 with ALU_zero_flag=0 is a plain increment.
- instruction_address = PC (registered).
- instruction_data is combinational: ROM[PC[log2(ROM_DEPTH_WORDS)+1:2]] when PC/4 < ROM_DEPTH_WORDS. Otherwise it is 0x00000013 (NOP), with no aliasing.
- ROM contents are fixed at elaboration:
  - word0 0x00208FE3, word1 0x000100B3, word2 0x00058133, word3 0x00058133, word4 0xFE000FCB.
  - All remaining words are 0x00000013.
- No write port, no stall, no exceptions.

Decomposition:
- common_pkg holds:
  - constants RISC_V_DATA_WIDTH=32, INSTRUCTION_WIDTH=32, INSTRUCTION_MEMORY_ADDRESS_WIDTH=32, NOP_INSTRUCTION=32'h00000013;
  - the default program as a constant word array.
- One sub-module, fetch_rom: combinational address-to-data lookup with out-of-range NOP.
- PC register, branch adder and mux live in the top module.

Test Plan:
- Hold rst=0 for 2 cycles, release, sample before the first edge: instruction_address=0x0 and instruction_data=0x00208FE3. Asserting rst mid-cycle clears the PC with no clock edge.
- Sequential run, branch inputs 0, 4 edges after release: addresses 0x4, 0x8, 0xC, 0x10 give data 0x000100B3, 0x00058133, 0x00058133, 0xFE000FCB.
- At PC=0x10 set ctrl_branch=1, ALU_zero_flag=1, offset=-6, one edge: PC=0x4 and data=0x000100B3. Then clear the branch inputs; the next edge gives PC=0x8.
- Single-condition cases:
  - at PC=0x10 with ctrl_branch=1, ALU_zero_flag=0, offset=-6: PC becomes 0x14 and data=0x00000013;
  - with ALU_zero_flag=1, ctrl_branch=0: also a plain increment.
- Forward branch at PC=0x0 with offset=+0x7E (byte offset 0xFC): PC becomes 0xFC, giving word63 NOP. The next edge gives PC=0x100, out of range, still NOP.
- Odd-alignment target: at PC=0x0 with offset=+1, PC becomes 0x0 (bits [1:0] cleared). Reset asserted the same cycle a branch is taken: PC=RESET_PC.
